// File: rtl/sd_drive_arbiter.sv
// sd_drive_arbiter: shares the single SD controller between NUM_DRV drive units.
// Picks a requesting drive (round-robin or fixed priority), latches its op/LSA,
// runs the req/ack/done exchange with the SD controller and returns a one-cycle
// drv_ack to the granted drive.
// Optional feature: define SDARB_WATCHDOG_EN to build a transfer watchdog that
// aborts a stalled REQ/XFER after TIMEOUT clocks and flags it with drv_err.
//
// Handshake: drv_req is a level held by the drive until it sees its drv_ack
// pulse; the arbiter will not re-grant that drive until it drops drv_req.
// sd_req is held high until sd_ack is sampled; sd_done is sampled in REQ or
// XFER only, so stray sd_ack/sd_done anywhere else has no effect.
module sd_drive_arbiter #(
  parameter int NUM_DRV = 8,
  parameter int OP_W    = 3,
  parameter int LSA_W   = 21,
  parameter int TIMEOUT = 2**20,
  localparam int SCAN_W = (NUM_DRV > 1) ? $clog2(NUM_DRV) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     prio_mode,
  input  logic [NUM_DRV-1:0]       drv_req,
  input  logic [NUM_DRV*OP_W-1:0]  drv_op,
  input  logic [NUM_DRV*LSA_W-1:0] drv_lsa,
  output logic [NUM_DRV-1:0]       drv_ack,
  output logic                     drv_err,
  output logic                     sd_req,
  output logic [OP_W-1:0]          sd_op,
  output logic [LSA_W-1:0]         sd_lsa,
  input  logic                     sd_ack,
  input  logic                     sd_done,
  output logic [SCAN_W-1:0]        sd_scan,
  output logic                     busy,
  output logic [2:0]               dbg_state
);

  typedef enum logic [2:0] {IDLE = 3'd0, REQ = 3'd1, XFER = 3'd2, ACK = 3'd3, HOLD = 3'd4} state_t;

  state_t            state, state_nx;
  logic [SCAN_W-1:0] last_grant;
  logic [SCAN_W-1:0] win;
  logic [OP_W-1:0]   win_op;
  logic [LSA_W-1:0]  win_lsa;
  logic              timeout_hit;

  assign dbg_state = state;

  // Winner search: fixed priority scans from 0, round-robin from last_grant+1 with wrap.
  always_comb begin
    logic found;
    int   idx;
    win   = last_grant;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_DRV; i++) begin
      if (prio_mode) begin
        idx = i;
      end else begin
        idx = int'(last_grant) + 1 + i;
        if (idx >= NUM_DRV) idx = idx - NUM_DRV;
      end
      if (!found && drv_req[SCAN_W'(idx)]) begin
        win   = SCAN_W'(idx);
        found = 1'b1;
      end
    end
    win_op  = drv_op[int'(win)*OP_W +: OP_W];
    win_lsa = drv_lsa[int'(win)*LSA_W +: LSA_W];
  end

  // Next-state logic; a watchdog expiry is treated like a completion (goes to ACK).
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (|drv_req) state_nx = REQ;
      REQ: begin
        if (sd_ack && sd_done) state_nx = ACK;
        else if (timeout_hit)  state_nx = ACK;
        else if (sd_ack)       state_nx = XFER;
      end
      XFER: if (sd_done || timeout_hit) state_nx = ACK;
      ACK:  state_nx = HOLD;
      HOLD: if (!drv_req[sd_scan]) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register and registered outputs, all derived from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      sd_req     <= 1'b0;
      drv_ack    <= '0;
      busy       <= 1'b0;
      sd_op      <= '0;
      sd_lsa     <= '0;
      sd_scan    <= '0;
      last_grant <= SCAN_W'(NUM_DRV - 1);
    end else if (clr) begin
      state      <= IDLE;
      sd_req     <= 1'b0;
      drv_ack    <= '0;
      busy       <= 1'b0;
      last_grant <= SCAN_W'(NUM_DRV - 1);
    end else begin
      state   <= state_nx;
      sd_req  <= (state_nx == REQ);
      busy    <= (state_nx != IDLE);
      drv_ack <= '0;
      if (state_nx == ACK) drv_ack[sd_scan] <= 1'b1;
      if (state == IDLE && state_nx == REQ) begin
        sd_scan    <= win;
        last_grant <= win;
        sd_op      <= win_op;
        sd_lsa     <= win_lsa;
      end
    end
  end

`ifdef SDARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT) + 1;
  logic [WD_W-1:0] wd_cnt;

  // Expiry is seen in the cycle whose count is TIMEOUT-1, so ACK lands TIMEOUT clocks after REQ entry.
  assign timeout_hit = (wd_cnt >= WD_W'(TIMEOUT - 1));

  // Watchdog counter: zero while idle (so it starts at 0 on REQ entry), counts in REQ/XFER.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
    end else if (clr || state == IDLE) begin
      wd_cnt <= '0;
    end else if (state == REQ || state == XFER) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Abort flag: set when ACK is entered because of expiry rather than sd_done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drv_err <= 1'b0;
    end else if (clr) begin
      drv_err <= 1'b0;
    end else begin
      drv_err <= timeout_hit && state_nx == ACK &&
                 ((state == REQ && !(sd_ack && sd_done)) || (state == XFER && !sd_done));
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign drv_err     = 1'b0;
`endif

endmodule

// File: tb/tb_sd_drive_arbiter.sv
// Directed bench for sd_drive_arbiter: reset/idle, single grant, round-robin
// order, fixed priority, coincident ack/done, clr mid-transfer and the
// watchdog (or the indefinite wait when the watchdog is not built).
module tb_sd_drive_arbiter;

  localparam int NUM_DRV = 8;
  localparam int OP_W    = 3;
  localparam int LSA_W   = 21;
  localparam int TIMEOUT = 64;
  localparam int SCAN_W  = 3;

  localparam logic [2:0] S_IDLE = 3'd0, S_REQ = 3'd1, S_XFER = 3'd2, S_ACK = 3'd3, S_HOLD = 3'd4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     clr;
  logic                     prio_mode;
  logic [NUM_DRV-1:0]       drv_req;
  logic [NUM_DRV*OP_W-1:0]  drv_op;
  logic [NUM_DRV*LSA_W-1:0] drv_lsa;
  logic [NUM_DRV-1:0]       drv_ack;
  logic                     drv_err;
  logic                     sd_req;
  logic [OP_W-1:0]          sd_op;
  logic [LSA_W-1:0]         sd_lsa;
  logic                     sd_ack;
  logic                     sd_done;
  logic [SCAN_W-1:0]        sd_scan;
  logic                     busy;
  logic [2:0]               dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  sd_drive_arbiter #(
    .NUM_DRV(NUM_DRV), .OP_W(OP_W), .LSA_W(LSA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr), .prio_mode(prio_mode),
    .drv_req(drv_req), .drv_op(drv_op), .drv_lsa(drv_lsa),
    .drv_ack(drv_ack), .drv_err(drv_err),
    .sd_req(sd_req), .sd_op(sd_op), .sd_lsa(sd_lsa),
    .sd_ack(sd_ack), .sd_done(sd_done),
    .sd_scan(sd_scan), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Time bound for the whole run
  initial begin
    #200000;
    $display("FAIL global_timeout: run did not complete, got hang, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  // Wait (bounded) for a grant, check it, finish it with coincident ack/done,
  // drop the drive's request and optionally re-raise it once back in IDLE.
  task automatic serve(input int exp_drv, input bit reraise, input string tag);
    int n;
    n = 0;
    while (!sd_req && n < 8) begin
      step();
      n++;
    end
    check({tag, "_req"}, 32'(sd_req), 32'd1);
    check({tag, "_scan"}, 32'(sd_scan), 32'(exp_drv));
    check({tag, "_op"}, 32'(sd_op), 32'(drv_op[exp_drv*OP_W +: OP_W]));
    check({tag, "_lsa"}, 32'(sd_lsa), 32'(drv_lsa[exp_drv*LSA_W +: LSA_W]));
    sd_ack = 1'b1; sd_done = 1'b1;
    step();
    sd_ack = 1'b0; sd_done = 1'b0;
    check({tag, "_st_ack"}, 32'(dbg_state), 32'(S_ACK));
    check({tag, "_ack"}, 32'(drv_ack), 32'(1) << exp_drv);
    drv_req[exp_drv] = 1'b0;
    step();
    check({tag, "_ack_1cyc"}, 32'(drv_ack), 32'd0);
    step();
    if (reraise) drv_req[exp_drv] = 1'b1;
  endtask

  initial begin
    int bad;
    int n;
    rst = 1'b0; clr = 1'b0; prio_mode = 1'b0;
    drv_req = '0; sd_ack = 1'b0; sd_done = 1'b0;
    for (int i = 0; i < NUM_DRV; i++) begin
      drv_op[i*OP_W +: OP_W]    = OP_W'(i + 3);
      drv_lsa[i*LSA_W +: LSA_W] = LSA_W'(32'h10000 + i * 32'h111);
    end

    // Reset
    repeat (3) step();
    check("rst_sd_req", 32'(sd_req), 0);
    check("rst_drv_ack", 32'(drv_ack), 0);
    check("rst_drv_err", 32'(drv_err), 0);
    check("rst_sd_op", 32'(sd_op), 0);
    check("rst_sd_lsa", 32'(sd_lsa), 0);
    check("rst_sd_scan", 32'(sd_scan), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    rst = 1'b1;
    bad = 0;
    repeat (100) begin
      step();
      if (sd_req || drv_ack != 0 || drv_err || busy || dbg_state != S_IDLE) bad++;
    end
    check("idle_100", 32'(bad), 0);

    // Single grant to drive 2
    drv_op[2*OP_W +: OP_W]    = 3'd1;
    drv_lsa[2*LSA_W +: LSA_W] = 21'h1ABCD;
    drv_req = 8'h04;
    step();
    check("sg_sd_req", 32'(sd_req), 1);
    check("sg_scan", 32'(sd_scan), 2);
    check("sg_op", 32'(sd_op), 1);
    check("sg_lsa", 32'(sd_lsa), 32'h1ABCD);
    check("sg_busy", 32'(busy), 1);
    drv_op[2*OP_W +: OP_W] = 3'd5;
    drv_lsa[2*LSA_W +: LSA_W] = 21'h00777;
    sd_ack = 1'b1;
    step();
    sd_ack = 1'b0;
    check("sg_st_xfer", 32'(dbg_state), 32'(S_XFER));
    check("sg_req_drop", 32'(sd_req), 0);
    bad = 0;
    repeat (10) begin
      step();
      if (drv_ack != 0) bad++;
    end
    check("sg_no_early_ack", 32'(bad), 0);
    sd_done = 1'b1;
    step();
    sd_done = 1'b0;
    check("sg_ack", 32'(drv_ack), 32'h04);
    check("sg_err", 32'(drv_err), 0);
    check("sg_op_held", 32'(sd_op), 1);
    check("sg_lsa_held", 32'(sd_lsa), 32'h1ABCD);
    step();
    check("sg_ack_1cyc", 32'(drv_ack), 0);
    check("sg_st_hold", 32'(dbg_state), 32'(S_HOLD));
    step();
    check("sg_hold_wait", 32'(dbg_state), 32'(S_HOLD));
    drv_req = 8'h00;
    step();
    check("sg_st_idle", 32'(dbg_state), 32'(S_IDLE));
    check("sg_busy_low", 32'(busy), 0);

    // clr restores last_grant so the round-robin order starts at drive 0
    clr = 1'b1;
    step();
    clr = 1'b0;

    // Round-robin with all drives requesting
    drv_req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      serve(k % NUM_DRV, (k < 8), $sformatf("rr%0d", k));
    end
    drv_req = 8'h00;
    step();

    // Fixed priority: after granting drive 6, round-robin would pick 7; priority picks 5
    drv_req = 8'h40;
    serve(6, 1'b0, "pre6");
    prio_mode = 1'b1;
    drv_req = 8'hA0;
    serve(5, 1'b0, "fp5");
    serve(7, 1'b0, "fp7");
    prio_mode = 1'b0;

    // clr during XFER: last_grant is 4 before clr, so without the reset drive 5 would win
    drv_req = 8'h10;
    serve_prefix: begin
      n = 0;
      while (!sd_req && n < 8) begin
        step();
        n++;
      end
    end
    check("clr_scan4", 32'(sd_scan), 4);
    sd_ack = 1'b1;
    step();
    sd_ack = 1'b0;
    check("clr_st_xfer", 32'(dbg_state), 32'(S_XFER));
    drv_req = 8'h21;
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_st_idle", 32'(dbg_state), 32'(S_IDLE));
    check("clr_sd_req", 32'(sd_req), 0);
    check("clr_no_ack", 32'(drv_ack), 0);
    check("clr_busy", 32'(busy), 0);
    sd_done = 1'b1;
    step();
    sd_done = 1'b0;
    check("clr_no_ack2", 32'(drv_ack), 0);
    serve(0, 1'b0, "clr_d0");
    serve(5, 1'b0, "clr_d5");
    drv_req = 8'h00;
    step();

    // Stalled transfer: no sd_ack from the SD controller
    drv_req = 8'h02;
    step();
    check("wd_req", 32'(sd_req), 1);
    check("wd_scan", 32'(sd_scan), 1);
`ifdef SDARB_WATCHDOG_EN
    n = 0;
    while (drv_ack == 0 && n < 100) begin
      step();
      n++;
    end
    check("wd_latency", 32'(n), 32'(TIMEOUT));
    check("wd_ack", 32'(drv_ack), 32'h02);
    check("wd_err", 32'(drv_err), 1);
    sd_ack = 1'b1; sd_done = 1'b1;
    step();
    sd_ack = 1'b0; sd_done = 1'b0;
    check("wd_late_ignored", 32'(drv_ack), 0);
    check("wd_st_hold", 32'(dbg_state), 32'(S_HOLD));
    drv_req = 8'h00;
    step();
    check("wd_st_idle", 32'(dbg_state), 32'(S_IDLE));
`else
    bad = 0;
    repeat (200) begin
      step();
      if (dbg_state != S_REQ || !sd_req || drv_err || drv_ack != 0) bad++;
    end
    check("nowd_wait", 32'(bad), 0);
    serve(1, 1'b0, "nowd_fin");
    check("nowd_err", 32'(drv_err), 0);
    drv_req = 8'h00;
    step();
    check("nowd_idle", 32'(dbg_state), 32'(S_IDLE));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
